// File: rtl/pcileech_sys_ctl_if.sv
// Board-side signal bundle of the system control stage: raw buttons in,
// resets, reload request, blink control and tick count out.
interface pcileech_sys_ctl_if;
    logic        user_sw1_n;
    logic        user_sw2_n;
    logic        rst;
    logic        ft601_rst_n;
    logic        rst_cfg_reload;
    logic        led_pwronblink;
    logic [63:0] tickcount64;

    modport master (
        input  user_sw1_n,
        input  user_sw2_n,
        output rst,
        output ft601_rst_n,
        output rst_cfg_reload,
        output led_pwronblink,
        output tickcount64
    );

    modport slave (
        output user_sw1_n,
        output user_sw2_n,
        input  rst,
        input  ft601_rst_n,
        input  rst_cfg_reload,
        input  led_pwronblink,
        input  tickcount64
    );
endinterface

// File: rtl/pcileech_sys_ctl.sv
// System control: button sync/debounce, reset generation and stretch,
// long-press config reload request, power-on blink and the 64-bit tick.
module pcileech_sys_ctl #(
    parameter int PARAM_RST_CYCLES      = 64,
    parameter int PARAM_DEBOUNCE_CYCLES = 1000000,
    parameter int PARAM_RELOAD_CYCLES   = 500000000,
    parameter int PARAM_BLINK_BIT       = 24,
    parameter int PARAM_BLINK_END_BIT   = 27
) (
    input  logic              clk,
    input  logic              rst_n,
    pcileech_sys_ctl_if.master sys
);
    localparam int DB_W    = $clog2(PARAM_DEBOUNCE_CYCLES + 1);
    localparam int PRESS_W = $clog2(PARAM_RELOAD_CYCLES + 1);
    localparam logic [DB_W-1:0]    DB_LAST    = DB_W'(PARAM_DEBOUNCE_CYCLES - 1);
    localparam logic [PRESS_W-1:0] PRESS_LAST = PRESS_W'(PARAM_RELOAD_CYCLES - 1);
    localparam logic [63:0]        RST_LAST   = 64'(PARAM_RST_CYCLES - 1);

    typedef enum logic [1:0] {S_HOLD, S_RUN, S_BTN, S_RELOAD} state_t;

    logic [1:0]            raw;
    logic [1:0]            sync_a;
    logic [1:0]            sync_b;
    logic [1:0]            db;
    logic [1:0][DB_W-1:0]  db_cnt;
    logic                  sw1_db;
    logic                  sw2_db;
    state_t                state;
    state_t                next_state;
    logic                  counting;
    logic [PRESS_W-1:0]    press_cnt;
    logic [63:0]           tick;
    logic                  rst_q;
    logic                  ft601_rst_n_q;
    logic                  reload_q;
    logic                  led_q;

    assign raw    = {sys.user_sw2_n, sys.user_sw1_n};
    assign sw1_db = db[0];
    assign sw2_db = db[1];

    // Buttons idle released (1); a change only lands after a full stable run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_a <= '1;
            sync_b <= '1;
            db     <= '1;
            db_cnt <= '0;
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
            for (int i = 0; i < 2; i++) begin
                if (sync_b[i] != db[i]) begin
                    if (db_cnt[i] == DB_LAST) begin
                        db[i]     <= sync_b[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 1'b1;
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_HOLD: begin
                if (!sw2_db)
                    next_state = S_BTN;
                else if (tick == RST_LAST)
                    next_state = S_RUN;
            end
            S_RUN: begin
                if (!sw2_db)
                    next_state = S_BTN;
            end
            S_BTN: begin
                if (sw2_db)
                    next_state = S_HOLD;
                else if (press_cnt == PRESS_LAST)
                    next_state = S_RELOAD;
            end
            S_RELOAD: begin
                if (sw2_db)
                    next_state = S_HOLD;
            end
            default: next_state = S_HOLD;
        endcase
    end

    // Tick clears on any edge touching a button state, so the post-release stretch restarts at 0.
    assign counting = (state == S_HOLD || state == S_RUN) &&
                      (next_state == S_HOLD || next_state == S_RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_HOLD;
            press_cnt     <= '0;
            tick          <= '0;
            rst_q         <= 1'b1;
            ft601_rst_n_q <= 1'b0;
            reload_q      <= 1'b0;
            led_q         <= 1'b0;
        end else begin
            state <= next_state;
            if (state == S_BTN)
                press_cnt <= (press_cnt == '1) ? press_cnt : press_cnt + 1'b1;
            else
                press_cnt <= '0;
            tick          <= counting ? tick + 64'd1 : 64'd0;
            rst_q         <= (next_state != S_RUN);
            ft601_rst_n_q <= (next_state == S_RUN);
            reload_q      <= (next_state == S_RELOAD);
            led_q         <= ~sw1_db ^ (tick[PARAM_BLINK_BIT] & ~|tick[63:PARAM_BLINK_END_BIT]);
        end
    end

    assign sys.rst            = rst_q;
    assign sys.ft601_rst_n    = ft601_rst_n_q;
    assign sys.rst_cfg_reload = reload_q;
    assign sys.led_pwronblink = led_q;
    assign sys.tickcount64    = tick;
endmodule

// File: tb/tb_pcileech_sys_ctl.sv
// Randomized bench for pcileech_sys_ctl against a cycle-level reference model.
module tb_pcileech_sys_ctl;
    localparam int RST_C = 4;
    localparam int DB_C  = 3;
    localparam int REL_C = 20;
    localparam int BB    = 2;
    localparam int BE    = 5;

    localparam int M_HOLD   = 0;
    localparam int M_RUN    = 1;
    localparam int M_BTN    = 2;
    localparam int M_RELOAD = 3;

    logic clk = 1'b0;
    logic rst_n;
    int   checkCount = 0;
    int   errorCount = 0;

    pcileech_sys_ctl_if bus ();

    pcileech_sys_ctl #(
        .PARAM_RST_CYCLES      (RST_C),
        .PARAM_DEBOUNCE_CYCLES (DB_C),
        .PARAM_RELOAD_CYCLES   (REL_C),
        .PARAM_BLINK_BIT       (BB),
        .PARAM_BLINK_END_BIT   (BE)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sys   (bus.master)
    );

    always #5 clk = ~clk;

    // Reference model: button pipelines as queues, behaviour as mode plus counters.
    logic        q1[$];
    logic        q2[$];
    logic        mDb1, mDb2;
    int          mRun1, mRun2;
    int          mMode;
    int          mPress;
    logic [63:0] mTick;
    logic        mRst, mFt, mReload, mLed;

    task automatic resetModel();
        q1 = '{1'b1, 1'b1};
        q2 = '{1'b1, 1'b1};
        mDb1 = 1'b1; mDb2 = 1'b1;
        mRun1 = 0; mRun2 = 0;
        mMode = M_HOLD; mPress = 0; mTick = 64'd0;
        mRst = 1'b1; mFt = 1'b0; mReload = 1'b0; mLed = 1'b0;
    endtask

    task automatic modelStep(input logic sw1, input logic sw2);
        logic        syn1, syn2, db1Old, db2Old;
        logic [63:0] tickOld;
        int          modeOld;
        syn1 = q1.pop_front(); q1.push_back(sw1);
        syn2 = q2.pop_front(); q2.push_back(sw2);
        db1Old = mDb1; db2Old = mDb2; tickOld = mTick; modeOld = mMode;
        if (syn1 != mDb1) begin
            mRun1++;
            if (mRun1 == DB_C) begin mDb1 = syn1; mRun1 = 0; end
        end else mRun1 = 0;
        if (syn2 != mDb2) begin
            mRun2++;
            if (mRun2 == DB_C) begin mDb2 = syn2; mRun2 = 0; end
        end else mRun2 = 0;
        case (modeOld)
            M_HOLD:   if (!db2Old) mMode = M_BTN; else if (tickOld == 64'(RST_C - 1)) mMode = M_RUN;
            M_RUN:    if (!db2Old) mMode = M_BTN;
            M_BTN:    if (db2Old) mMode = M_HOLD; else if (mPress == REL_C - 1) mMode = M_RELOAD;
            default:  if (db2Old) mMode = M_HOLD;
        endcase
        mPress = (modeOld == M_BTN) ? mPress + 1 : 0;
        if (modeOld <= M_RUN && mMode <= M_RUN) mTick = tickOld + 64'd1;
        else mTick = 64'd0;
        mRst    = (mMode != M_RUN);
        mFt     = (mMode == M_RUN);
        mReload = (mMode == M_RELOAD);
        mLed    = ~db1Old ^ (((tickOld >> BB) & 64'd1) == 64'd1 && (tickOld >> BE) == 64'd0);
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic compareAll();
        checkOutput("rst", 64'(bus.rst), 64'(mRst));
        checkOutput("ft601_rst_n", 64'(bus.ft601_rst_n), 64'(mFt));
        checkOutput("rst_cfg_reload", 64'(bus.rst_cfg_reload), 64'(mReload));
        checkOutput("led_pwronblink", 64'(bus.led_pwronblink), 64'(mLed));
        checkOutput("tickcount64", bus.tickcount64, mTick);
    endtask

    task automatic applyStimulus(input logic sw1, input logic sw2, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            bus.user_sw1_n = sw1;
            bus.user_sw2_n = sw2;
            @(posedge clk);
            modelStep(sw1, sw2);
            #1 compareAll();
        end
    endtask

    initial begin
        int budget;
        rst_n = 1'b0;
        bus.user_sw1_n = 1'b1;
        bus.user_sw2_n = 1'b1;
        resetModel();
        #12 compareAll();
        @(negedge clk) rst_n = 1'b1;
        $display("[TB] power-on");
        applyStimulus(1'b1, 1'b1, 40);
        $display("[TB] glitch and presses");
        applyStimulus(1'b1, 1'b0, 2);
        applyStimulus(1'b1, 1'b1, 10);
        applyStimulus(1'b1, 1'b0, 10);
        applyStimulus(1'b1, 1'b1, 20);
        applyStimulus(1'b1, 1'b0, 40);
        applyStimulus(1'b1, 1'b1, 20);
        $display("[TB] blink");
        applyStimulus(1'b0, 1'b1, 15);
        applyStimulus(1'b1, 1'b1, 40);
        $display("[TB] random segments");
        for (int seg = 0; seg < 25; seg++)
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(1, 45));
        applyStimulus(1'b1, 1'b1, 20);
        $display("[TB] async reset in reload");
        budget = 0;
        while (mMode != M_RELOAD && budget < 80) begin
            applyStimulus(1'b1, 1'b0, 1);
            budget++;
        end
        checkOutput("reload_reached", 64'(mMode == M_RELOAD), 64'd1);
        applyStimulus(1'b1, 1'b0, 2);
        checkOutput("reload_high", 64'(bus.rst_cfg_reload), 64'd1);
        #2 rst_n = 1'b0;
        resetModel();
        #1 compareAll();
        bus.user_sw2_n = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1 compareAll();
        end
        @(negedge clk) rst_n = 1'b1;
        applyStimulus(1'b1, 1'b1, 12);
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end
endmodule
